// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic MAC array.
package systolic_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

   // Widest accumulator the extend-and-multiply helper supports.
   localparam int unsigned MAX_W = 64;

   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

   // Cycles from the last-beat accept until the bottom-right PE has its final term.
   function automatic int unsigned flush_len(input int unsigned rows, input int unsigned cols);
      return rows + cols - 1;
   endfunction

   // Operands arrive zero-padded; sign-extend from bit dw-1 when signed. Low bits of the
   // full-width product equal the AW-bit product of the AW-extended operands.
   function automatic logic [MAX_W-1:0] ext_mul(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int unsigned      dw,
                                                input bit               is_signed);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] sbit;
      logic [MAX_W-1:0] ax;
      logic [MAX_W-1:0] bx;
      mask = {MAX_W{1'b1}} << dw;
      sbit = {{(MAX_W-1){1'b0}}, 1'b1} << (dw - 1);
      ax   = (is_signed && |(a & sbit)) ? (a | mask) : a;
      bx   = (is_signed && |(b & sbit)) ? (b | mask) : b;
      return ax * bx;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell; forwards its operands and tags right and down one edge later.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 32,
   parameter int unsigned SIGNED = 0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] a_i,
   input  logic          a_vld_i,
   input  logic          a_first_i,
   input  logic [DW-1:0] b_i,
   input  logic          b_vld_i,
   output logic [DW-1:0] a_o,
   output logic          a_vld_o,
   output logic          a_first_o,
   output logic [DW-1:0] b_o,
   output logic          b_vld_o,
   output logic [AW-1:0] acc_o
);

   logic [DW-1:0] a_q, b_q;
   logic          a_vld_q, a_first_q, b_vld_q;
   logic [AW-1:0] acc_q;
   logic [AW-1:0] prod;

   assign prod = AW'(ext_mul(MAX_W'(a_q), MAX_W'(b_q), DW, SIGNED != 0));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_q       <= '0;
         a_vld_q   <= 1'b0;
         a_first_q <= 1'b0;
         b_q       <= '0;
         b_vld_q   <= 1'b0;
         acc_q     <= '0;
      end else begin
         a_q       <= a_i;
         a_vld_q   <= a_vld_i;
         a_first_q <= a_first_i;
         b_q       <= b_i;
         b_vld_q   <= b_vld_i;
         // The first beat of a tile replaces the old sum instead of adding to it.
         if (a_vld_q && b_vld_q) begin
            acc_q <= a_first_q ? prod : acc_q + prod;
         end
      end
   end

   assign a_o       = a_q;
   assign a_vld_o   = a_vld_q;
   assign a_first_o = a_first_q;
   assign b_o       = b_q;
   assign b_vld_o   = b_vld_q;
   assign acc_o     = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary ROWS x COLS systolic array computing C = A x B over a streamed K.
module systolic_mac_array
   import systolic_pkg::*;
#(
   parameter int unsigned ROWS   = 3,
   parameter int unsigned COLS   = 5,
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 32,
   parameter int unsigned SIGNED = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    io_in_valid,
   output logic                    io_in_ready,
   input  logic                    io_in_last,
   input  logic [ROWS*DW-1:0]      io_ain,
   input  logic [COLS*DW-1:0]      io_bin,
   output logic                    io_out_valid,
   input  logic                    io_out_ready,
   output logic [ROWS*COLS*AW-1:0] io_cout
);

   localparam int unsigned FLUSH_LEN = flush_len(ROWS, COLS);
   localparam int unsigned CNT_W     = $clog2(FLUSH_LEN + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, first_beat;

   assign accept     = io_in_valid & io_in_ready;
   assign first_beat = accept & (state_q == IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      io_in_ready  = 1'b0;
      io_out_valid = 1'b0;
      unique case (state_q)
         IDLE, LOAD: begin
            io_in_ready = 1'b1;
            if (accept) begin
               state_d = io_in_last ? FLUSH : LOAD;
               if (io_in_last) cnt_d = CNT_W'(FLUSH_LEN);
            end
         end
         FLUSH: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = DONE;
         end
         DONE: begin
            io_out_valid = 1'b1;
            if (io_out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Horizontal (a) and vertical (b) operand/tag nets; the extra column/row are the edge outputs.
   logic [DW-1:0] a_h       [ROWS][COLS+1];
   logic          a_vld_h   [ROWS][COLS+1];
   logic          a_first_h [ROWS][COLS+1];
   logic [DW-1:0] b_v       [ROWS+1][COLS];
   logic          b_vld_v   [ROWS+1][COLS];
   logic [AW-1:0] acc       [ROWS][COLS];

   for (genvar i = 0; i < ROWS; i++) begin : g_askew
      if (i == 0) begin : g_direct
         assign a_h[i][0]       = io_ain[slice_lo(i, DW) +: DW];
         assign a_vld_h[i][0]   = accept;
         assign a_first_h[i][0] = first_beat;
      end else begin : g_dly
         logic [DW-1:0] d_q [i];
         logic          v_q [i];
         logic          f_q [i];
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int s = 0; s < i; s++) begin
                  d_q[s] <= '0;
                  v_q[s] <= 1'b0;
                  f_q[s] <= 1'b0;
               end
            end else begin
               d_q[0] <= io_ain[slice_lo(i, DW) +: DW];
               v_q[0] <= accept;
               f_q[0] <= first_beat;
               for (int s = 1; s < i; s++) begin
                  d_q[s] <= d_q[s-1];
                  v_q[s] <= v_q[s-1];
                  f_q[s] <= f_q[s-1];
               end
            end
         end
         assign a_h[i][0]       = d_q[i-1];
         assign a_vld_h[i][0]   = v_q[i-1];
         assign a_first_h[i][0] = f_q[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_bskew
      if (j == 0) begin : g_direct
         assign b_v[0][j]     = io_bin[slice_lo(j, DW) +: DW];
         assign b_vld_v[0][j] = accept;
      end else begin : g_dly
         logic [DW-1:0] d_q [j];
         logic          v_q [j];
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int s = 0; s < j; s++) begin
                  d_q[s] <= '0;
                  v_q[s] <= 1'b0;
               end
            end else begin
               d_q[0] <= io_bin[slice_lo(j, DW) +: DW];
               v_q[0] <= accept;
               for (int s = 1; s < j; s++) begin
                  d_q[s] <= d_q[s-1];
                  v_q[s] <= v_q[s-1];
               end
            end
         end
         assign b_v[0][j]     = d_q[j-1];
         assign b_vld_v[0][j] = v_q[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         systolic_pe #(
            .DW     (DW),
            .AW     (AW),
            .SIGNED (SIGNED)
         ) u_pe (
            .clock     (clock),
            .reset     (reset),
            .a_i       (a_h[i][j]),
            .a_vld_i   (a_vld_h[i][j]),
            .a_first_i (a_first_h[i][j]),
            .b_i       (b_v[i][j]),
            .b_vld_i   (b_vld_v[i][j]),
            .a_o       (a_h[i][j+1]),
            .a_vld_o   (a_vld_h[i][j+1]),
            .a_first_o (a_first_h[i][j+1]),
            .b_o       (b_v[i+1][j]),
            .b_vld_o   (b_vld_v[i+1][j]),
            .acc_o     (acc[i][j])
         );
         assign io_cout[slice_lo(i * COLS + j, AW) +: AW] = acc[i][j];
      end
   end

   logic unused_edge;
   always_comb begin
      unused_edge = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         unused_edge = unused_edge ^ (^a_h[i][COLS]) ^ a_vld_h[i][COLS] ^ a_first_h[i][COLS];
      end
      for (int j = 0; j < COLS; j++) begin
         unused_edge = unused_edge ^ (^b_v[ROWS][j]) ^ b_vld_v[ROWS][j];
      end
   end

endmodule

// File: doc/systolic_mac_array.md
Name: systolic_mac_array

Overview:
- Parametrised output-stationary systolic matrix-multiply array, computing C = A x B over a streamed inner dimension K.
- Each accepted beat carries one column of A (ROWS elements) and one row of B (COLS elements).
- Skew registers feed a ROWS x COLS grid of multiply-accumulate PEs.
- A valid/ready result handshake presents the full C tile; the block sits between the operand fetch buffers and the result writeback.

Parameters:
- ROWS, 3, number of A elements per beat and number of PE rows (>=1)
- COLS, 5, number of B elements per beat and number of PE columns (>=1)
- DW, 32, operand element width
- AW, 32, accumulator and result element width (>=DW)
- SIGNED, 0, 0 = unsigned multiply; 1 = two's-complement multiply with operands sign-extended to AW

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- io_in_valid  input  1  operand beat valid
- io_in_ready  output  1  block accepts a beat
- io_in_last  input  1  qualifies an accepted beat as the final beat (k = K-1)
- io_ain  input  ROWS*DW  A column; element i at bits [i*DW +: DW]
- io_bin  input  COLS*DW  B row; element j at bits [j*DW +: DW]
- io_out_valid  output  1  result tile valid
- io_out_ready  input  1  consumer takes the tile
- io_cout  output  ROWS*COLS*AW  C tile; element (i,j) at bits [(i*COLS+j)*AW +: AW]

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all accumulators 0, all skew registers and valid tags 0.
- Reset output values: io_in_ready=1, io_out_valid=0, io_cout=0.
- Accept: a beat is accepted on an edge where io_in_valid & io_in_ready.
- FSM IDLE:
  - io_in_ready=1.
  - An accepted beat clears every accumulator, and that beat's product counts as the first term, so no stale sum leaks.
  - Next state is FLUSH if io_in_last, else LOAD.
- FSM LOAD:
  - io_in_ready=1.
  - An accepted beat with io_in_last goes to FLUSH.
  - io_in_valid=0 cycles are bubbles: tags propagate as invalid and accumulators are unchanged.
- FSM FLUSH:
  - io_in_ready=0.
  - Down-counter loaded with ROWS+COLS-1 on the last-beat accept.
  - When the counter expires, go to DONE.
- FSM DONE:
  - io_in_ready=0, io_out_valid=1, io_cout stable.
  - On io_out_ready=1, go to IDLE and drop io_out_valid.
  - io_cout keeps its value until the next first beat clears it.
- Skew and timing:
  - Operand a_i is delayed i edges and b_j is delayed j edges, each with a 1-bit valid tag.
  - PE(i,j) adds a_i*b_j of beat k on edge t_k+i+j+1, where t_k is the accept edge of beat k.
  - The last PE update is on edge t_last+ROWS+COLS-1.
  - io_out_valid rises on that same edge, so latency from the last-beat accept to io_out_valid is ROWS+COLS-1 cycles (7 for 3x5).
- Arithmetic:
  - The product is extended to AW per SIGNED and truncated to AW.
  - The accumulator wraps modulo 2^AW, with no saturation or overflow flag.
- Inputs are not sampled while io_in_ready=0. io_in_last is ignored unless the beat is accepted.
- A single-beat tile (K=1, first beat with io_in_last) is legal: IDLE goes directly to FLUSH.
- Reset mid-operation (any state) aborts the tile: outputs return to their reset values, and no partial result or io_out_valid pulse is produced.
- Back-to-back tiles: the earliest next accept is one cycle after the io_out_valid & io_out_ready edge.

Decomposition:
- Package systolic_pkg:
  - state enum {IDLE, LOAD, FLUSH, DONE}
  - function to compute flattened slice offsets
  - function for the SIGNED-aware extend-and-multiply
  - localparam for the flush length ROWS+COLS-1
- Sub-module systolic_pe:
  - one MAC cell with an operand-and-tag pass-through register to the right and downward neighbours
  - accumulator with clear-on-first input
  - instantiated ROWS x COLS by generate

Test Plan:
- Reset: hold reset=0 with random inputs -> io_in_ready=1, io_out_valid=0, io_cout all 0. Release -> unchanged until the first accept.
- K=1 tile: ain={1,2,3}, bin={10,20,30,40,50}, io_in_last=1 -> io_out_valid rises 7 cycles after the accept. cout(0,0)=10, cout(1,2)=60, cout(2,4)=150.
- Bubbles: 3 beats with all elements=1, 2 idle cycles between beats 1 and 2 -> all 15 cout=3, io_out_valid 7 cycles after the last accept, io_in_ready=0 during FLUSH/DONE.
- Backpressure and clear: hold io_out_ready=0 for 10 cycles in DONE -> io_out_valid and io_cout stable. Then:
  - raise io_out_ready -> IDLE, io_in_ready=1
  - next tile ain=all 2, bin=all 3, K=1 -> all cout=6, not accumulated onto the previous tile
- Width/sign: SIGNED=0, ain=0x0001_0000, bin=0x0001_0000 -> cout=0 (wrap). SIGNED=1, ain=0xFFFF_FFFF, bin=2, two beats -> cout=0xFFFF_FFFC (-4).
- Mid-operation reset: assert reset=0 two cycles into FLUSH -> io_out_valid stays 0, io_cout=0, io_in_ready=1. A subsequent K=1 tile computes correctly.
